keypad_entry_buffer: RTL and testbench
======================================

# keypad_entry_buffer

Downstream consumer of the keypad scanner. Turns the scanner's one-clock `key_pressed` pulses and 4-bit key codes into a multi-digit BCD number entry with editing keys. Completed entries go out on a valid/ready handshake, and the live buffer is exported for a seven-segment display driver. An idle timer discards stale partial entries.

## Interface
- `NUM_DIGITS`, 4: buffer depth in BCD digits (1..8).
- `TIMEOUT_TICKS`, 500_000_000: idle clocks before a non-empty buffer auto-clears (5 s at 100 MHz); 0 disables the timer.
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `value`  in  4  key code from the scanner: 0-9 are digits, 10=A, 11=B, 12=C, 13=D, 14=`*`, 15=`#`.
- `key_pressed`  in  1  one-clock strobe; `value` is valid when this is high.
- `disp_bcd`  out  4*NUM_DIGITS  live buffer; the most recent digit is in bits [3:0].
- `disp_count`  out  4  number of digits currently held (0..NUM_DIGITS).
- `entry_bcd`  out  4*NUM_DIGITS  committed entry.
- `entry_count`  out  4  digit count of the committed entry.
- `entry_term`  out  4  terminator code: 15 for `#`, 10/11/13 for A/B/D.
- `entry_valid`  out  1  committed entry available.
- `entry_ready`  in  1  consumer accepts the entry.
- `overflow`  out  1  one-clock pulse: digit rejected because the buffer is full.
- `dropped`  out  1  one-clock pulse: key ignored during HOLD.

## Operation
- Two states: EDIT and HOLD. Reset enters EDIT.
- EDIT, `key_pressed`=1, key handling:
  - Digit 0-9, count < NUM_DIGITS: buffer shifts left one nibble, new digit goes in [3:0], count increments.
  - Digit 0-9, count = NUM_DIGITS: buffer is unchanged; `overflow` pulses.
  - `*` (14): backspace. Buffer shifts right one nibble, the top nibble is filled with 0, count decrements. No effect when count = 0.
  - C (12): buffer is cleared to 0 and count to 0.
  - `#`, A, B, D with count >= 1: buffer, count and code are copied to `entry_*`; the live buffer clears; the block goes to HOLD.
  - `#`, A, B, D with count = 0: ignored; no state change.
- HOLD:
  - `entry_valid`=1, and `entry_*` stay stable.
  - `entry_valid`&`entry_ready` at a rising edge returns the block to EDIT and drops `entry_valid`.
  - A key arriving in HOLD is discarded and pulses `dropped`; the live buffer does not change.
- Idle timer:
  - Counts clocks in EDIT while count > 0 and no key arrives.
  - Resets to 0 on any `key_pressed`, and when count = 0.
  - On reaching TIMEOUT_TICKS-1 it clears the buffer and count.
  - Held at 0 in HOLD.
  - Width is 32 bits, saturating.
- Unused high nibbles of `disp_bcd` are always 0.

## Timing
- Reset values:
  - `disp_bcd`, `entry_bcd`, `disp_count`, `entry_count` = 0.
  - `entry_term` = 0.
  - `entry_valid`, `overflow`, `dropped` = 0.
  - State = EDIT, timer = 0.
- Reset asserted mid-HOLD drops `entry_valid` immediately and discards the entry.
- Key-to-output latency:
  - `disp_*` updates at the first rising edge after the `key_pressed` cycle.
  - On a commit, `entry_valid` rises at that same edge.
  - `overflow` and `dropped` are high for exactly the cycle following the key.
- `entry_ready` may be held high permanently. Each entry is still valid for at least one cycle, and throughput is one entry per key.
- A key and a handshake at the same edge in HOLD: the handshake completes and the key is dropped (pulses `dropped`).
- A key and timer expiry in the same cycle: the key wins and the timer restarts. The key acts on the uncleared buffer.
- `value` is sampled only when `key_pressed`=1. It is a don't-care otherwise.
- `key_pressed` strobes are at least 100_000 cycles apart from the scanner, but the block must be correct with strobes on consecutive cycles.

## Test plan
- Digits, then commit: keys 1,2,3,`#` with `entry_ready`=0. Expect `disp_bcd` = 0x0001, then 0x0012, then 0x0123. `entry_valid`=1 with `entry_bcd`=0x0123, `entry_count`=3, `entry_term`=15, and `disp_count`=0. Raise `entry_ready` and `entry_valid` falls next edge.
- Overflow and backspace: keys 9,8,7,6,5. Expect `disp_bcd`=0x9876 and one `overflow` pulse. Then `*` gives 0x0987 with count 3. `*` three more times gives 0x0000 with count 0. A further `*` leaves it 0x0000.
- Hold drop: commit 4,D, then key 7 before ready. Expect `dropped` pulse, `entry_bcd`=0x0004, `entry_term`=13, `disp_bcd`=0x0000. After the handshake, key 7 gives `disp_bcd`=0x0007.
- Empty commit and clear: `#` at count 0 leaves `entry_valid`=0. Keys 5,C give `disp_bcd`=0, count 0.
- Timeout, with TIMEOUT_TICKS=20:
  - Key 3, then idle. The buffer clears exactly 20 cycles after the key.
  - Key 3, then key 4 at cycle 19 (coincident with expiry). Expect `disp_bcd`=0x0034, and the timer restarts.
- Async reset in HOLD, then back-to-back strobes:
  - Assert `rst` mid-cycle while `entry_valid`=1. All outputs go to 0 without waiting for a clock edge.
  - Then strobes on consecutive cycles, keys 1,2,A, give `entry_bcd`=0x0012 and `entry_term`=10.

Source files
------------

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: collects BCD digits from scanner strobes, supports backspace/clear,
// commits terminated entries over valid/ready and discards stale partial entries on idle.
module keypad_entry_buffer #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned TIMEOUT_TICKS = 500_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              value,
    input  logic                    key_pressed,
    output logic [4*NUM_DIGITS-1:0] disp_bcd,
    output logic [3:0]              disp_count,
    output logic [4*NUM_DIGITS-1:0] entry_bcd,
    output logic [3:0]              entry_count,
    output logic [3:0]              entry_term,
    output logic                    entry_valid,
    input  logic                    entry_ready,
    output logic                    overflow,
    output logic                    dropped
);

    localparam int unsigned W = 4 * NUM_DIGITS;
    localparam logic [3:0]  NumDigits = 4'(NUM_DIGITS);
    // Guarded by the TIMEOUT_TICKS != 0 check, so the wrap at zero is never used.
    localparam logic [31:0] TimerLast = (TIMEOUT_TICKS == 0) ? 32'd0 : 32'(TIMEOUT_TICKS - 1);

    typedef enum logic {StEdit, StHold} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  buf_q, buf_d;
    logic [3:0]    count_q, count_d;
    logic [W-1:0]  entry_bcd_q, entry_bcd_d;
    logic [3:0]    entry_count_q, entry_count_d;
    logic [3:0]    entry_term_q, entry_term_d;
    logic          entry_valid_q, entry_valid_d;
    logic          overflow_q, overflow_d;
    logic          dropped_q, dropped_d;
    logic [31:0]   timer_q, timer_d;

    logic is_digit;
    logic is_term;
    logic timer_hit;

    assign is_digit  = (value <= 4'd9);
    assign is_term   = (value == 4'd10) || (value == 4'd11) || (value == 4'd13) ||
                       (value == 4'd15);
    assign timer_hit = (TIMEOUT_TICKS != 0) && (timer_q == TimerLast);

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        count_d       = count_q;
        entry_bcd_d   = entry_bcd_q;
        entry_count_d = entry_count_q;
        entry_term_d  = entry_term_q;
        entry_valid_d = entry_valid_q;
        overflow_d    = 1'b0;
        dropped_d     = 1'b0;
        timer_d       = timer_q;

        case (state_q)
            StEdit: begin
                if (key_pressed) begin
                    // A key always wins over a coincident timer expiry.
                    timer_d = 32'd0;
                    if (is_digit) begin
                        if (count_q < NumDigits) begin
                            buf_d   = (buf_q << 4) | W'(value);
                            count_d = count_q + 4'd1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else if (value == 4'd14) begin
                        if (count_q != 4'd0) begin
                            buf_d   = buf_q >> 4;
                            count_d = count_q - 4'd1;
                        end
                    end else if (value == 4'd12) begin
                        buf_d   = '0;
                        count_d = 4'd0;
                    end else if (is_term && (count_q != 4'd0)) begin
                        entry_bcd_d   = buf_q;
                        entry_count_d = count_q;
                        entry_term_d  = value;
                        entry_valid_d = 1'b1;
                        buf_d         = '0;
                        count_d       = 4'd0;
                        state_d       = StHold;
                    end
                end else if (count_q == 4'd0) begin
                    timer_d = 32'd0;
                end else if (timer_hit) begin
                    buf_d   = '0;
                    count_d = 4'd0;
                    timer_d = 32'd0;
                end else if (timer_q != 32'hFFFF_FFFF) begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StHold: begin
                timer_d   = 32'd0;
                dropped_d = key_pressed;
                if (entry_ready) begin
                    entry_valid_d = 1'b0;
                    state_d       = StEdit;
                end
            end
            default: begin
                state_d = StEdit;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StEdit;
            buf_q         <= '0;
            count_q       <= 4'd0;
            entry_bcd_q   <= '0;
            entry_count_q <= 4'd0;
            entry_term_q  <= 4'd0;
            entry_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            dropped_q     <= 1'b0;
            timer_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            count_q       <= count_d;
            entry_bcd_q   <= entry_bcd_d;
            entry_count_q <= entry_count_d;
            entry_term_q  <= entry_term_d;
            entry_valid_q <= entry_valid_d;
            overflow_q    <= overflow_d;
            dropped_q     <= dropped_d;
            timer_q       <= timer_d;
        end
    end

    assign disp_bcd    = buf_q;
    assign disp_count  = count_q;
    assign entry_bcd   = entry_bcd_q;
    assign entry_count = entry_count_q;
    assign entry_term  = entry_term_q;
    assign entry_valid = entry_valid_q;
    assign overflow    = overflow_q;
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer: directed scenarios with literal expectations plus randomized
// key traffic checked every cycle against a digit-list model of the entry rules.
module tb_keypad_entry_buffer;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    value;
    logic          key_pressed;
    logic [4*N-1:0] disp_bcd;
    logic [3:0]    disp_count;
    logic [4*N-1:0] entry_bcd;
    logic [3:0]    entry_count;
    logic [3:0]    entry_term;
    logic          entry_valid;
    logic          entry_ready;
    logic          overflow;
    logic          dropped;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    keypad_entry_buffer #(
        .NUM_DIGITS   (N),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .key_pressed(key_pressed),
        .disp_bcd   (disp_bcd),
        .disp_count (disp_count),
        .entry_bcd  (entry_bcd),
        .entry_count(entry_count),
        .entry_term (entry_term),
        .entry_valid(entry_valid),
        .entry_ready(entry_ready),
        .overflow   (overflow),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: live digits as a list (oldest first), entry as a separate list.
    int unsigned m_dig[$];
    int unsigned m_ent[$];
    int unsigned m_term;
    bit          m_valid;
    bit          m_ovf;
    bit          m_drop;
    int unsigned m_idle;

    function automatic int unsigned pack(input int unsigned d[$]);
        int unsigned v = 0;
        foreach (d[i]) v = v * 16 + d[i];
        return v;
    endfunction

    task automatic model_reset();
        m_dig.delete();
        m_ent.delete();
        m_term  = 0;
        m_valid = 0;
        m_ovf   = 0;
        m_drop  = 0;
        m_idle  = 0;
    endtask

    task automatic model_step(input bit kp, input int unsigned v, input bit rdy);
        m_ovf  = 0;
        m_drop = 0;
        if (m_valid) begin
            m_drop = kp;
            m_idle = 0;
            if (rdy) m_valid = 0;
        end else if (kp) begin
            m_idle = 0;
            if (v <= 9) begin
                if (m_dig.size() < N) m_dig.push_back(v);
                else m_ovf = 1;
            end else if (v == 14) begin
                if (m_dig.size() > 0) void'(m_dig.pop_back());
            end else if (v == 12) begin
                m_dig.delete();
            end else if (m_dig.size() > 0) begin
                m_ent   = m_dig;
                m_term  = v;
                m_valid = 1;
                m_dig.delete();
            end
        end else if (m_dig.size() == 0) begin
            m_idle = 0;
        end else begin
            m_idle++;
            // Buffer survives TO idle cycles' worth of edges minus nothing: clears on the TO-th.
            if (m_idle == TO) begin
                m_dig.delete();
                m_idle = 0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step(key_pressed, 32'(value), entry_ready);
        #1;
        if (started) begin
            check("disp_bcd",    32'(disp_bcd),    pack(m_dig));
            check("disp_count",  32'(disp_count),  m_dig.size());
            check("entry_bcd",   32'(entry_bcd),   pack(m_ent));
            check("entry_count", 32'(entry_count), m_ent.size());
            check("entry_term",  32'(entry_term),  m_term);
            check("entry_valid", 32'(entry_valid), 32'(m_valid));
            check("overflow",    32'(overflow),    32'(m_ovf));
            check("dropped",     32'(dropped),     32'(m_drop));
        end
    end

    task automatic key(input logic [3:0] v);
        @(negedge clk);
        value       = v;
        key_pressed = 1'b1;
        @(negedge clk);
        key_pressed = 1'b0;
        value       = 4'($urandom_range(0, 15));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic handshake();
        @(negedge clk);
        entry_ready = 1'b1;
        @(negedge clk);
        entry_ready = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        value       = 4'd0;
        key_pressed = 1'b0;
        entry_ready = 1'b0;
        started     = 1'b1;
        idle(3);
        rst = 1'b0;
        check("rst_disp", 32'(disp_bcd), 0);
        check("rst_valid", 32'(entry_valid), 0);

        // Digits then commit.
        key(4'd1); check("d1", 32'(disp_bcd), 32'h0001);
        key(4'd2); check("d12", 32'(disp_bcd), 32'h0012);
        key(4'd3); check("d123", 32'(disp_bcd), 32'h0123);
        key(4'd15);
        check("c_valid", 32'(entry_valid), 1);
        check("c_bcd", 32'(entry_bcd), 32'h0123);
        check("c_cnt", 32'(entry_count), 3);
        check("c_term", 32'(entry_term), 15);
        check("c_disp_cnt", 32'(disp_count), 0);
        handshake();
        check("hs_valid", 32'(entry_valid), 0);

        // Overflow and backspace.
        key(4'd9); key(4'd8); key(4'd7); key(4'd6);
        @(negedge clk); value = 4'd5; key_pressed = 1'b1;
        @(negedge clk); key_pressed = 1'b0;
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_disp", 32'(disp_bcd), 32'h9876);
        key(4'd14); check("bs1", 32'(disp_bcd), 32'h0987); check("bs1_cnt", 32'(disp_count), 3);
        key(4'd14); key(4'd14); key(4'd14);
        check("bs4", 32'(disp_bcd), 0); check("bs4_cnt", 32'(disp_count), 0);
        key(4'd14); check("bs5", 32'(disp_bcd), 0);

        // Drop during hold.
        key(4'd4); key(4'd13); key(4'd7);
        check("drop_pulse", 32'(dropped), 1);
        check("drop_bcd", 32'(entry_bcd), 32'h0004);
        check("drop_term", 32'(entry_term), 13);
        check("drop_disp", 32'(disp_bcd), 0);
        handshake();
        key(4'd7); check("after_hs", 32'(disp_bcd), 32'h0007);

        // Empty commit and clear.
        key(4'd12); key(4'd15); check("empty_commit", 32'(entry_valid), 0);
        key(4'd5); key(4'd12);
        check("clr_disp", 32'(disp_bcd), 0); check("clr_cnt", 32'(disp_count), 0);

        // Timeout: clears on the 20th edge after the key edge.
        key(4'd3); idle(19); check("to_before", 32'(disp_count), 1);
        idle(1); check("to_after", 32'(disp_count), 0);
        // Key coincident with expiry acts on the uncleared buffer and restarts the timer.
        key(4'd3); idle(18); key(4'd4);
        check("to_coinc", 32'(disp_bcd), 32'h0034);
        idle(19); check("to_restart_before", 32'(disp_count), 2);
        idle(1); check("to_restart_after", 32'(disp_count), 0);

        // Async reset mid-hold.
        key(4'd1); key(4'd15); check("pre_rst_valid", 32'(entry_valid), 1);
        @(posedge clk); #2; rst = 1'b1; #1;
        check("arst_valid", 32'(entry_valid), 0);
        check("arst_ebcd", 32'(entry_bcd), 0);
        check("arst_term", 32'(entry_term), 0);
        check("arst_ecnt", 32'(entry_count), 0);
        @(negedge clk); rst = 1'b0;

        // Back-to-back strobes.
        @(negedge clk); value = 4'd1; key_pressed = 1'b1;
        @(negedge clk); value = 4'd2;
        @(negedge clk); value = 4'd10;
        @(negedge clk); key_pressed = 1'b0;
        check("b2b_valid", 32'(entry_valid), 1);
        check("b2b_bcd", 32'(entry_bcd), 32'h0012);
        check("b2b_term", 32'(entry_term), 10);
        handshake();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) begin
                key_pressed = 1'b0;
                idle(int'($urandom_range(15, 25)));
            end
            key_pressed = ($urandom_range(0, 99) < 40);
            value = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
            entry_ready = ($urandom_range(0, 99) < 35);
        end
        @(negedge clk);
        key_pressed = 1'b0;
        entry_ready = 1'b1;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
